// File: rtl/bus2real_ramp.sv
// rtl/bus2real_ramp.sv - WIDTH-bit code to real level converter with slew-limited ramp.
// Optional BUS2REAL_RETARGET_EN: accept a new target while a ramp is in progress.
`ifndef OUTPUT_REAL
`define OUTPUT_REAL output real
`endif

module bus2real_ramp #(
  parameter int unsigned WIDTH      = 8,
  parameter real         vh         = 1.0,
  parameter real         vl         = 0.0,
  parameter int unsigned STEP       = 4,
  parameter int unsigned RESET_CODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_code,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] cur_code,
  output logic             busy,
  output logic             done,
  `OUTPUT_REAL             out,
  `OUTPUT_REAL             outb
);

  localparam logic [WIDTH-1:0] RST_CODE = WIDTH'(RESET_CODE);
  localparam logic [WIDTH-1:0] MAX_CODE = '1;
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  // STEP clamped to the code range so the reach test never sees a truncated STEP.
  localparam logic [WIDTH:0]   STEP_LIM = (STEP > int'(MAX_CODE)) ? {1'b0, MAX_CODE}
                                                                   : (WIDTH+1)'(STEP);
`ifdef BUS2REAL_RETARGET_EN
  localparam logic RETARGET = 1'b1;
`else
  localparam logic RETARGET = 1'b0;
`endif

  typedef enum logic {IDLE, RAMP} state_t;

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        target_q, target_d;
  logic [WIDTH-1:0]        cur_q, cur_d;
  logic                    done_q, done_d;
  logic                    accept;
  logic [WIDTH-1:0]        goal;
  logic signed [WIDTH:0]   delta;
  logic [WIDTH:0]          mag;
  logic                    close;
  logic [WIDTH-1:0]        stepped;

  assign in_ready = ~rst & ((state_q == IDLE) | RETARGET);
  assign accept   = in_valid & in_ready;
  assign goal     = accept ? in_code : target_q;

  // The step is only taken when |delta| > STEP, so it cannot overshoot or wrap.
  always_comb begin
    delta   = $signed({1'b0, goal}) - $signed({1'b0, cur_q});
    mag     = delta[WIDTH] ? -delta : delta;
    close   = (STEP == 0) || (mag <= STEP_LIM);
    stepped = delta[WIDTH] ? (cur_q - STEP_W) : (cur_q + STEP_W);
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cur_d    = cur_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          target_d = in_code;
          if (in_code == cur_q) begin
            done_d = 1'b1;
          end else begin
            state_d = RAMP;
            cur_d   = close ? goal : stepped;
          end
        end
      end
      RAMP: begin
        target_d = goal;
        if (close) begin
          cur_d   = goal;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cur_d = stepped;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= RST_CODE;
      cur_q    <= RST_CODE;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cur_q    <= cur_d;
      done_q   <= done_d;
    end
  end

  assign cur_code = cur_q;
  assign busy     = (state_q == RAMP);
  assign done     = done_q;
  assign out      = vl + (vh - vl) * real'(cur_q) / real'(MAX_CODE);
  assign outb     = vh + vl - out;

endmodule

// File: tb/tb_bus2real_ramp.sv
// tb/tb_bus2real_ramp.sv - directed bench for bus2real_ramp, three STEP settings (3, 4, 0).
module tb_bus2real_ramp;

  localparam int  W  = 4;
  localparam real VH = 1.5;
  localparam real VL = 0.0;
  localparam int  RC = 5;
`ifdef BUS2REAL_RETARGET_EN
  localparam bit RET = 1'b1;
`else
  localparam bit RET = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] code_a [3];
  logic       valid_a[3];
  logic       ready_a[3];
  logic [3:0] cur_a  [3];
  logic       busy_a [3];
  logic       done_a [3];
  real        out_a  [3];
  real        outb_a [3];

  int checks = 0;
  int errors = 0;

  int m_cur [3] = '{RC, RC, RC};
  int m_tgt [3] = '{RC, RC, RC};
  bit m_ramp[3] = '{1'b0, 1'b0, 1'b0};
  bit m_done[3] = '{1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bus2real_ramp #(
      .WIDTH(W), .vh(VH), .vl(VL),
      .STEP((g == 0) ? 3 : ((g == 1) ? 4 : 0)),
      .RESET_CODE(RC)
    ) u_dut (
      .clk(clk), .rst(rst),
      .in_code(code_a[g]), .in_valid(valid_a[g]), .in_ready(ready_a[g]),
      .cur_code(cur_a[g]), .busy(busy_a[g]), .done(done_a[g]),
      .out(out_a[g]), .outb(outb_a[g])
    );
  end

  function automatic int step_of(int k);
    return (k == 0) ? 3 : ((k == 1) ? 4 : 0);
  endfunction

  // Target if reachable this clock, otherwise one full step toward it.
  function automatic int approach(int c, int t, int s);
    if (s == 0 || ((t - c) <= s && (c - t) <= s)) return t;
    return (t > c) ? c + s : c - s;
  endfunction

  task automatic chk(string name, int k, logic [31:0] act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0d expected %0d", name, k, act, exp);
    end
  endtask

  task automatic chk_r(string name, int k, real act, real exp);
    checks++;
    if (act - exp > 1.0e-6 || exp - act > 1.0e-6) begin
      errors++;
      $display("FAIL %s[%0d] got %f expected %f", name, k, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    bit acc;
    int nxt;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_cur[k] = RC; m_tgt[k] = RC; m_ramp[k] = 1'b0; m_done[k] = 1'b0;
      end else begin
        acc       = valid_a[k] && (!m_ramp[k] || RET);
        m_done[k] = 1'b0;
        if (acc) m_tgt[k] = code_a[k];
        if (!m_ramp[k] && acc && code_a[k] == m_cur[k]) begin
          m_done[k] = 1'b1;
        end else if (m_ramp[k] || acc) begin
          nxt = approach(m_cur[k], m_tgt[k], step_of(k));
          if (m_ramp[k] && nxt == m_tgt[k]) begin
            m_ramp[k] = 1'b0;
            m_done[k] = 1'b1;
          end else begin
            m_ramp[k] = 1'b1;
          end
          m_cur[k] = nxt;
        end
      end
    end
  end

  always @(negedge clk) begin
    real lvl;
    for (int k = 0; k < 3; k++) begin
      lvl = VL + (VH - VL) * m_cur[k] / 15.0;
      chk("cur_code", k, cur_a[k], m_cur[k]);
      chk("busy", k, busy_a[k], m_ramp[k]);
      chk("done", k, done_a[k], m_done[k]);
      chk("in_ready", k, ready_a[k], (!rst && (!m_ramp[k] || RET)) ? 1 : 0);
      chk_r("out", k, out_a[k], lvl);
      chk_r("outb", k, outb_a[k], VH + VL - lvl);
    end
  end

  task automatic send(int k, int code);
    @(negedge clk);
    #1;
    code_a[k]  = 4'(code);
    valid_a[k] = 1'b1;
    @(posedge clk);
    #1;
    valid_a[k] = 1'b0;
  endtask

  task automatic wait_idle(int k);
    for (int n = 0; n < 60 && m_ramp[k]; n++) @(negedge clk);
    if (m_ramp[k]) begin
      checks++;
      errors++;
      $display("FAIL wait_idle[%0d] ramp still running after 60 cycles", k);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      code_a[k]  = '0;
      valid_a[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 0, ready_a[0], 1);
    chk("cur_after_rst", 0, cur_a[0], 5);

    // STEP=3 upward ramp 0 -> 15
    send(0, 0);
    wait_idle(0);
    send(0, 15);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ramp_up_cur", 0, cur_a[0], 3 * (i + 1));
      chk_r("ramp_up_out", 0, out_a[0], 0.3 * (i + 1));
      chk("ramp_up_busy", 0, busy_a[0], (i < 4) ? 1 : 0);
      chk("ramp_up_done", 0, done_a[0], (i < 4) ? 0 : 1);
      chk("ramp_up_ready", 0, ready_a[0], (i < 4) ? int'(RET) : 1);
    end
    @(negedge clk);
    chk("ramp_up_done_end", 0, done_a[0], 0);

    // new target offered at cur_code=6
    send(0, 0);
    wait_idle(0);
    send(0, 15);
    @(negedge clk);
    @(negedge clk);
    #1;
    code_a[0]  = 4'd4;
    valid_a[0] = 1'b1;
    @(posedge clk);
    #1 valid_a[0] = 1'b0;
    @(negedge clk);
    chk("retarget_cur", 0, cur_a[0], RET ? 4 : 9);
    chk("retarget_done", 0, done_a[0], RET ? 1 : 0);
    wait_idle(0);
    chk("retarget_final", 0, cur_a[0], RET ? 4 : 15);

    // asynchronous reset mid-ramp at cur_code=6
    send(0, 0);
    wait_idle(0);
    send(0, 15);
    @(negedge clk);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_cur", 0, cur_a[0], 5);
    chk_r("rst_out", 0, out_a[0], 0.5);
    chk_r("rst_outb", 0, outb_a[0], 1.0);
    chk("rst_ready", 0, ready_a[0], 0);
    chk("rst_busy", 0, busy_a[0], 0);
    chk("rst_done", 0, done_a[0], 0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    send(0, 15);
    @(negedge clk);
    chk("post_rst_cur", 0, cur_a[0], 8);
    wait_idle(0);
    chk("post_rst_final", 0, cur_a[0], 15);

    // STEP=4 downward 15 -> 2
    send(1, 15);
    wait_idle(1);
    send(1, 2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ramp_dn_cur", 1, cur_a[1], (i < 3) ? 11 - 4 * i : 2);
      chk("ramp_dn_done", 1, done_a[1], (i < 3) ? 0 : 1);
    end
    @(negedge clk);
    chk("ramp_dn_done_end", 1, done_a[1], 0);

    // STEP=0 jump, then accept of the code already held
    send(2, 0);
    wait_idle(2);
    send(2, 9);
    @(negedge clk);
    chk("jump_cur", 2, cur_a[2], 9);
    chk("jump_busy", 2, busy_a[2], 1);
    @(negedge clk);
    chk("jump_done", 2, done_a[2], 1);
    chk("jump_busy_end", 2, busy_a[2], 0);
    send(2, 9);
    @(negedge clk);
    chk("same_busy", 2, busy_a[2], 0);
    chk("same_done", 2, done_a[2], 1);
    @(negedge clk);
    chk("same_done_end", 2, done_a[2], 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
